serial_frame_deserializer: RTL and testbench

- Consumes the serial bit stream (`dout`) leaving the shift-register stage, one bit per `clk` when qualified.
- Hunts for a sync word, then assembles a fixed number of MSB-first parallel words.
- Presents each word on a valid/ready interface to downstream logic.
- Flags sync detection, frame completion and dropped words.

---
 rtl/serial_frame_deserializer.sv | 169 ++++++++++++++++
 tb/tb_serial_frame_deserializer.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/serial_frame_deserializer.sv
// serial_frame_deserializer
//
// Hunts the incoming serial stream for a WIDTH-bit sync word, then assembles
// FRAME_LEN MSB-first words. Each word is offered on a single-entry
// valid/ready output register.
//
// Ports:
//   clk         rising-edge clock
//   reset       synchronous, active-high reset
//   din         serial data bit
//   din_valid   din is sampled only when high
//   out_data    assembled word, MSB = first bit received
//   out_valid   out_data holds an unaccepted word
//   out_ready   downstream accepts when out_valid & out_ready
//   sync_det    one-cycle pulse after the sync word matched
//   frame_done  one-cycle pulse after the last word of a frame
//   in_frame    high while collecting frame words
//   overflow    sticky: a completed word was dropped (register full)
//
// state   | meaning
// --------+----------------------------------------------------------
// HUNT    | shifting din through the sync window, waiting for SYNC
// COLLECT | assembling FRAME_LEN data words

module serial_frame_deserializer #(
    parameter int               WIDTH     = 8,
    parameter logic [WIDTH-1:0] SYNC      = 8'hA5,
    parameter int               FRAME_LEN = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             din,
    input  logic             din_valid,
    output logic [WIDTH-1:0] out_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             sync_det,
    output logic             frame_done,
    output logic             in_frame,
    output logic             overflow
);

    localparam logic [0:0] ST_HUNT    = 1'b0;
    localparam logic [0:0] ST_COLLECT = 1'b1;

    localparam int             CW        = $clog2(WIDTH + 1);
    localparam logic [CW-1:0]  LAST_BIT  = CW'(WIDTH - 1);
    localparam logic [CW-1:0]  FILL_FULL = CW'(WIDTH);
    localparam logic [7:0]     LAST_WORD = 8'(FRAME_LEN - 1);

    logic [0:0]       state_q, state_d;
    // Only the oldest WIDTH-1 bits need storing: the newest bit is din itself
    // on the edge that evaluates a match or completes a word.
    logic [WIDTH-2:0] win_q, win_d;
    logic [WIDTH-2:0] asm_q, asm_d;
    logic [CW-1:0]    fill_q, fill_d;
    logic [CW-1:0]    bit_cnt_q, bit_cnt_d;
    logic [7:0]       word_cnt_q, word_cnt_d;
    logic [WIDTH-1:0] out_data_q, out_data_d;
    logic             out_valid_q, out_valid_d;
    logic             sync_det_q, sync_det_d;
    logic             frame_done_q, frame_done_d;
    logic             overflow_q, overflow_d;

    logic [WIDTH-1:0] win_next;
    logic [WIDTH-1:0] word_next;
    logic             word_done;

    assign win_next  = {win_q, din};
    assign word_next = {asm_q, din};

    always_comb begin
        state_d      = state_q;
        win_d        = win_q;
        asm_d        = asm_q;
        fill_d       = fill_q;
        bit_cnt_d    = bit_cnt_q;
        word_cnt_d   = word_cnt_q;
        out_data_d   = out_data_q;
        out_valid_d  = out_valid_q;
        overflow_d   = overflow_q;
        sync_det_d   = 1'b0;
        frame_done_d = 1'b0;
        word_done    = 1'b0;

        if (din_valid) begin
            if (state_q == ST_HUNT) begin
                win_d = win_next[WIDTH-2:0];
                if (fill_q != FILL_FULL) begin
                    fill_d = fill_q + 1'b1;
                end
                // fill_q counts bits before this one, so WIDTH-1 means this
                // edge supplies the WIDTH-th valid bit since entering HUNT.
                if (fill_q >= LAST_BIT && win_next == SYNC) begin
                    state_d    = ST_COLLECT;
                    sync_det_d = 1'b1;
                    bit_cnt_d  = '0;
                    word_cnt_d = '0;
                end
            end else begin
                asm_d = word_next[WIDTH-2:0];
                if (bit_cnt_q == LAST_BIT) begin
                    bit_cnt_d = '0;
                    word_done = 1'b1;
                    if (word_cnt_q == LAST_WORD) begin
                        frame_done_d = 1'b1;
                        state_d      = ST_HUNT;
                        win_d        = '0;
                        fill_d       = '0;
                        word_cnt_d   = '0;
                    end else begin
                        word_cnt_d = word_cnt_q + 1'b1;
                    end
                end else begin
                    bit_cnt_d = bit_cnt_q + 1'b1;
                end
            end
        end

        // A word arriving while the held word is being accepted replaces it
        // with no bubble; a word arriving into a full, stalled register is lost.
        if (word_done) begin
            if (!out_valid_q || out_ready) begin
                out_data_d  = word_next;
                out_valid_d = 1'b1;
            end else begin
                overflow_d = 1'b1;
            end
        end else if (out_valid_q && out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= ST_HUNT;
            win_q        <= '0;
            asm_q        <= '0;
            fill_q       <= '0;
            bit_cnt_q    <= '0;
            word_cnt_q   <= '0;
            out_data_q   <= '0;
            out_valid_q  <= 1'b0;
            sync_det_q   <= 1'b0;
            frame_done_q <= 1'b0;
            overflow_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            win_q        <= win_d;
            asm_q        <= asm_d;
            fill_q       <= fill_d;
            bit_cnt_q    <= bit_cnt_d;
            word_cnt_q   <= word_cnt_d;
            out_data_q   <= out_data_d;
            out_valid_q  <= out_valid_d;
            sync_det_q   <= sync_det_d;
            frame_done_q <= frame_done_d;
            overflow_q   <= overflow_d;
        end
    end

    assign out_data   = out_data_q;
    assign out_valid  = out_valid_q;
    assign sync_det   = sync_det_q;
    assign frame_done = frame_done_q;
    assign in_frame   = (state_q == ST_COLLECT);
    assign overflow   = overflow_q;

endmodule

// File: tb/tb_serial_frame_deserializer.sv
module tb_serial_frame_deserializer;

    logic       clk = 1'b0;
    logic       reset;
    logic       din;
    logic       din_valid;

    logic [7:0] out_data;
    logic       out_valid, out_ready, sync_det, frame_done, in_frame, overflow;

    logic [7:0] out_data4;
    logic       out_valid4, out_ready4, sync_det4, frame_done4, in_frame4, overflow4;

    int total = 0;
    int bad   = 0;
    logic seen_sync;

    logic [7:0] q[$];
    logic [7:0] q4[$];

    always #5 clk = ~clk;

    serial_frame_deserializer #(.WIDTH(8), .SYNC(8'hA5), .FRAME_LEN(2)) dut (
        .clk(clk), .reset(reset), .din(din), .din_valid(din_valid),
        .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
        .sync_det(sync_det), .frame_done(frame_done), .in_frame(in_frame),
        .overflow(overflow)
    );

    serial_frame_deserializer #(.WIDTH(8), .SYNC(8'hA5), .FRAME_LEN(4)) dut4 (
        .clk(clk), .reset(reset), .din(din), .din_valid(din_valid),
        .out_data(out_data4), .out_valid(out_valid4), .out_ready(out_ready4),
        .sync_det(sync_det4), .frame_done(frame_done4), .in_frame(in_frame4),
        .overflow(overflow4)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic sb_pop(input string tag, input logic [7:0] obs, input bit four);
        logic [7:0] exp;
        if (four ? (q4.size() == 0) : (q.size() == 0)) begin
            total++;
            bad++;
            $error("FAIL %s observed=%0h expected=none(queue empty)", tag, obs);
        end else begin
            exp = four ? q4.pop_front() : q.pop_front();
            chk(tag, 32'(obs), 32'(exp));
        end
    endtask

    // Inputs are set by the caller; handshakes that will fire on the coming
    // edge are scored before it, then time advances to just after the edge.
    task automatic tick();
        if (!reset) begin
            if (out_valid && out_ready)   sb_pop("sb_word",  out_data,  1'b0);
            if (out_valid4 && out_ready4) sb_pop("sb_word4", out_data4, 1'b1);
        end
        @(posedge clk);
        #1;
        seen_sync = seen_sync | sync_det;
    endtask

    task automatic send_bits(input logic [31:0] v, input int n);
        for (int i = n - 1; i >= 0; i--) begin
            din       = v[i];
            din_valid = 1'b1;
            tick();
        end
    endtask

    task automatic send_bits_gap(input logic [31:0] v, input int n);
        for (int i = n - 1; i >= 0; i--) begin
            din       = v[i];
            din_valid = 1'b1;
            tick();
            din_valid = 1'b0;
            tick();
        end
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_data"},  32'(out_data),   32'h0);
        chk({tag, "_valid"}, 32'(out_valid),  32'h0);
        chk({tag, "_sync"},  32'(sync_det),   32'h0);
        chk({tag, "_fdone"}, 32'(frame_done), 32'h0);
        chk({tag, "_infr"},  32'(in_frame),   32'h0);
        chk({tag, "_ovf"},   32'(overflow),   32'h0);
    endtask

    task automatic do_reset(input int n);
        reset     = 1'b1;
        din_valid = 1'b1;
        for (int i = 0; i < n; i++) begin
            din = ~din;
            tick();
        end
        reset     = 1'b0;
        din_valid = 1'b0;
        seen_sync = 1'b0;
    endtask

    initial begin
        reset      = 1'b1;
        din        = 1'b0;
        din_valid  = 1'b0;
        out_ready  = 1'b0;
        out_ready4 = 1'b0;
        seen_sync  = 1'b0;

        // Reset with toggling din, then a long run of zeros
        do_reset(3);
        chk_zero("rst");
        send_bits(32'h0, 20);
        chk("zeros_no_sync", 32'(seen_sync), 32'h0);

        // Basic frame A5,3C,C3
        out_ready = 1'b1;
        q.push_back(8'h3C);
        q.push_back(8'hC3);
        send_bits(32'h52, 7);
        chk("basic_sync_early", 32'(sync_det), 32'h0);
        send_bits(32'h1, 1);
        chk("basic_sync", 32'(sync_det), 32'h1);
        chk("basic_infr", 32'(in_frame), 32'h1);
        send_bits(32'h1E, 7);
        chk("basic_sync_pulse", 32'(sync_det), 32'h0);
        chk("basic_w0_early", 32'(out_valid), 32'h0);
        send_bits(32'h0, 1);
        chk("basic_w0_valid", 32'(out_valid), 32'h1);
        chk("basic_w0_data", 32'(out_data), 32'h3C);
        send_bits(32'h1, 1);
        chk("basic_w0_onecyc", 32'(out_valid), 32'h0);
        send_bits(32'h21, 6);
        send_bits(32'h1, 1);
        chk("basic_w1_valid", 32'(out_valid), 32'h1);
        chk("basic_w1_data", 32'(out_data), 32'hC3);
        chk("basic_fdone", 32'(frame_done), 32'h1);
        chk("basic_infr_end", 32'(in_frame), 32'h0);
        chk("basic_ovf", 32'(overflow), 32'h0);
        din_valid = 1'b0;
        tick();
        chk("basic_fdone_pulse", 32'(frame_done), 32'h0);
        chk("basic_drain", 32'(out_valid), 32'h0);

        // Misaligned sync: FF then A5
        do_reset(2);
        send_bits(32'hFF, 8);
        send_bits(32'h52, 7);
        chk("align_no_early", 32'(seen_sync), 32'h0);
        send_bits(32'h1, 1);
        chk("align_sync", 32'(sync_det), 32'h1);
        din_valid = 1'b0;
        tick();
        chk("align_sync_pulse", 32'(sync_det), 32'h0);

        // Fewer than WIDTH bits after reset can never match
        do_reset(2);
        send_bits(32'h52, 7);
        chk("short_no_sync", 32'(seen_sync), 32'h0);
        send_bits(32'h1, 1);
        chk("short_eighth_sync", 32'(sync_det), 32'h1);

        // Backpressure: A5,11,22 with out_ready low
        do_reset(2);
        out_ready = 1'b0;
        q.push_back(8'h11);
        send_bits(32'hA5, 8);
        send_bits(32'h11, 8);
        chk("bp_w0_valid", 32'(out_valid), 32'h1);
        chk("bp_w0_data", 32'(out_data), 32'h11);
        send_bits(32'h22, 8);
        chk("bp_hold_data", 32'(out_data), 32'h11);
        chk("bp_hold_valid", 32'(out_valid), 32'h1);
        chk("bp_ovf", 32'(overflow), 32'h1);
        chk("bp_fdone", 32'(frame_done), 32'h1);
        out_ready = 1'b1;
        din_valid = 1'b0;
        tick();
        chk("bp_accept", 32'(out_valid), 32'h0);
        chk("bp_ovf_sticky", 32'(overflow), 32'h1);

        // Gapped input: din_valid alternating
        do_reset(2);
        out_ready = 1'b1;
        q.push_back(8'h5A);
        q.push_back(8'h96);
        send_bits_gap(32'hA5, 8);
        chk("gap_sync_seen", 32'(seen_sync), 32'h1);
        chk("gap_infr", 32'(in_frame), 32'h1);
        send_bits_gap(32'h2D, 7);
        chk("gap_w0_early", 32'(out_valid), 32'h0);
        send_bits(32'h0, 1);
        chk("gap_w0_valid", 32'(out_valid), 32'h1);
        chk("gap_w0_data", 32'(out_data), 32'h5A);
        din_valid = 1'b0;
        tick();
        chk("gap_w0_drain", 32'(out_valid), 32'h0);
        chk("gap_freeze_infr", 32'(in_frame), 32'h1);
        send_bits_gap(32'h4B, 7);
        send_bits(32'h0, 1);
        chk("gap_w1_data", 32'(out_data), 32'h96);
        chk("gap_fdone", 32'(frame_done), 32'h1);
        din_valid = 1'b0;
        tick();

        // FRAME_LEN=4: accept of word 1 coincides with completion of word 2
        do_reset(2);
        out_ready  = 1'b0;
        out_ready4 = 1'b0;
        q4.push_back(8'h12);
        q4.push_back(8'h34);
        send_bits(32'hA5, 8);
        chk("sim_infr4", 32'(in_frame4), 32'h1);
        send_bits(32'h12, 8);
        chk("sim_w0_valid4", 32'(out_valid4), 32'h1);
        chk("sim_w0_data4", 32'(out_data4), 32'h12);
        send_bits(32'h1A, 7);
        din        = 1'b0;
        din_valid  = 1'b1;
        out_ready4 = 1'b1;
        tick();
        out_ready4 = 1'b0;
        chk("sim_w1_data4", 32'(out_data4), 32'h34);
        chk("sim_w1_valid4", 32'(out_valid4), 32'h1);
        chk("sim_ovf4", 32'(overflow4), 32'h0);
        din_valid  = 1'b0;
        out_ready4 = 1'b1;
        tick();
        out_ready4 = 1'b0;
        chk("sim_drain4", 32'(out_valid4), 32'h0);

        // Reset in the middle of a frame with a word pending
        do_reset(2);
        out_ready = 1'b0;
        send_bits(32'hA5, 8);
        send_bits(32'h3C, 8);
        send_bits(32'h0, 3);
        chk("mid_pending", 32'(out_valid), 32'h1);
        do_reset(1);
        chk_zero("mid_rst");
        out_ready = 1'b1;
        q.push_back(8'h0F);
        q.push_back(8'hF0);
        send_bits(32'hA5, 8);
        chk("mid_sync", 32'(sync_det), 32'h1);
        send_bits(32'h0F, 8);
        chk("mid_w0_data", 32'(out_data), 32'h0F);
        send_bits(32'hF0, 8);
        chk("mid_w1_data", 32'(out_data), 32'hF0);
        chk("mid_fdone", 32'(frame_done), 32'h1);
        chk("mid_ovf", 32'(overflow), 32'h0);
        din_valid = 1'b0;
        tick();
        chk("mid_drain", 32'(out_valid), 32'h0);

        chk("sb_empty", 32'(q.size()), 32'h0);
        chk("sb_empty4", 32'(q4.size()), 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
